// File: rtl/crc4_frame_encoder.sv
// Serial CRC-4 (x^4+x+1) frame encoder: latches a 64-bit payload and channel tag,
// folds BITS_PER_CYCLE payload bits per clock into the CRC, then holds {data, crc, chan} on valid/ready.
module crc4_frame_encoder #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [3:0]  CRC_INIT       = 4'h0,
    parameter int          CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [3:0]       in_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [3:0]       out_crc,
    output logic [3:0]       out_chan,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int BEATS = 64 / BPC;

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
            $error("crc4_frame_encoder: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [63:0]        shift_q;
    logic [3:0]         crc_q;
    logic [3:0]         crc_d;
    logic [6:0]         beat_q;
    logic [63:0]        out_data_q;
    logic [3:0]         out_crc_q;
    logic [3:0]         out_chan_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   count_q;

    // Folds a group of bits into the CRC, oldest (highest index) bit first.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic [BPC-1:0] bits);
        logic [3:0] r;
        logic       fb;
        r = c;
        for (int i = BPC - 1; i >= 0; i--) begin
            fb = r[3] ^ bits[i];
            r  = {r[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_step(crc_q, shift_q[63 -: BPC]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            crc_q       <= '0;
            beat_q      <= '0;
            out_data_q  <= '0;
            out_crc_q   <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_q    <= in_data;
                        out_data_q <= in_data;
                        out_chan_q <= in_chan;
                        crc_q      <= CRC_INIT;
                        beat_q     <= '0;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    crc_q   <= crc_d;
                    shift_q <= {shift_q[63-BPC:0], {BPC{1'b0}}};
                    beat_q  <= beat_q + 7'd1;
                    if (beat_q == 7'(BEATS - 1)) begin
                        // Result is published only here so out_crc never shows a partial value.
                        out_crc_q   <= crc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so the upstream never sees a ready while the block is held in reset.
    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_crc     = out_crc_q;
    assign out_chan    = out_chan_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_crc4_frame_encoder.sv
// Bench for crc4_frame_encoder: three instances (BPC=1, BPC=8, BPC=4/CNT_W=4) checked against
// a GF(2) polynomial-remainder model built from a table of x^j mod (x^4+x+1).
module tb_crc4_frame_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [3:0]  in_chan = '0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;
    logic [2:0]  irdy, ov, bsy;
    logic [63:0] od  [3];
    logic [3:0]  oc  [3];
    logic [3:0]  och [3];
    logic [15:0] fc_a, fc_b;
    logic [3:0]  fc_c;

    int checks = 0;
    int errors = 0;
    int exp_fc [3];
    logic [3:0] pw [15];

    always #5 clock = ~clock;

    crc4_frame_encoder #(.BITS_PER_CYCLE(1), .CNT_W(16)) u_enc1 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .out_crc(oc[0]), .out_chan(och[0]), .busy(bsy[0]), .frame_count(fc_a));

    crc4_frame_encoder #(.BITS_PER_CYCLE(8), .CNT_W(16)) u_enc8 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .out_crc(oc[1]), .out_chan(och[1]), .busy(bsy[1]), .frame_count(fc_b));

    crc4_frame_encoder #(.BITS_PER_CYCLE(4), .CNT_W(4)) u_enc4 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od[2]), .out_crc(oc[2]), .out_chan(och[2]), .busy(bsy[2]), .frame_count(fc_c));

    function automatic int beats(input int k);
        return (k == 0) ? 64 : (k == 1) ? 8 : 16;
    endfunction

    function automatic logic [15:0] get_fc(input int k);
        return (k == 0) ? fc_a : (k == 1) ? fc_b : {12'h000, fc_c};
    endfunction

    function automatic logic [15:0] want_fc(input int k);
        return (k == 2) ? 16'(exp_fc[k] % 16) : 16'(exp_fc[k] % 65536);
    endfunction

    // CRC = data(x) * x^4 mod P: XOR of x^(i+4) over set bits; x^15 = 1 since P is primitive.
    function automatic logic [3:0] crc_model(input logic [63:0] d);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 64; i++)
            if (d[i]) r = r ^ pw[(i + 4) % 15];
        return r;
    endfunction

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (irdy[k] !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (irdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready dut%0d: in_ready=%b required 1 within 200 cycles", k, irdy[k]);
        end
    endtask

    // Accepts one payload, then checks the exact cycle out_valid rises and the frame contents.
    task automatic frame_to_done(input int k, input logic [63:0] d, input logic [3:0] c,
                                 input logic [3:0] ec, input string tag);
        wait_ready(k);
        @(negedge clock);
        in_data = d; in_chan = c; iv[k] = 1'b1;
        @(posedge clock); #1;
        iv[k] = 1'b0;
        checks++;
        if (bsy[k] !== 1'b1 || irdy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s accept dut%0d: busy=%b in_ready=%b required 1/0", tag, k, bsy[k], irdy[k]);
        end
        repeat (beats(k) - 1) @(posedge clock);
        #1;
        checks++;
        if (ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid dut%0d: out_valid=%b required 0 at beat %0d", tag, k, ov[k], beats(k) - 1);
        end
        @(posedge clock); #1;
        checks++;
        if (ov[k] !== 1'b1 || oc[k] !== ec || od[k] !== d || och[k] !== c) begin
            errors++;
            $display("FAIL %s frame dut%0d: valid=%b crc=%h data=%h chan=%h required 1 %h %h %h",
                     tag, k, ov[k], oc[k], od[k], och[k], ec, d, c);
        end
    endtask

    task automatic handoff(input int k, input string tag);
        @(negedge clock);
        ordy[k] = 1'b1;
        @(posedge clock); #1;
        ordy[k] = 1'b0;
        exp_fc[k]++;
        checks++;
        if (ov[k] !== 1'b0 || irdy[k] !== 1'b1 || bsy[k] !== 1'b0 || get_fc(k) !== want_fc(k)) begin
            errors++;
            $display("FAIL %s handoff dut%0d: valid=%b in_ready=%b busy=%b count=%0d required 0 1 0 %0d",
                     tag, k, ov[k], irdy[k], bsy[k], get_fc(k), want_fc(k));
        end
    endtask

    task automatic run_frame(input int k, input logic [63:0] d, input logic [3:0] c,
                             input logic [3:0] ec, input string tag);
        frame_to_done(k, d, c, ec, tag);
        handoff(k, tag);
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irdy[k] !== 1'b0 || ov[k] !== 1'b0 || od[k] !== 64'h0 || oc[k] !== 4'h0 ||
                och[k] !== 4'h0 || bsy[k] !== 1'b0 || get_fc(k) !== 16'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b vld=%b data=%h crc=%h chan=%h busy=%b cnt=%0d required all 0",
                         k, irdy[k], ov[k], od[k], oc[k], och[k], bsy[k], get_fc(k));
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (irdy !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 111", irdy);
        end
    endtask

    task automatic test_vectors();
        run_frame(0, 64'h2, 4'h0, 4'h6, "vec_2");
        run_frame(0, 64'h1, 4'h3, 4'h3, "vec_1");
        run_frame(0, 64'h0, 4'h7, 4'h0, "vec_0");
        run_frame(0, 64'h8, 4'h9, 4'hB, "vec_8");
        run_frame(0, 64'h8000_0000_0000_0000, 4'hA, 4'hB, "vec_msb");
        run_frame(0, {64{1'b1}}, 4'hC, 4'h2, "vec_ones");
    endtask

    task automatic test_bpc8();
        run_frame(1, {64{1'b1}}, 4'hF, 4'h2, "bpc8_ones");
        run_frame(1, 64'h2, 4'h1, 4'h6, "bpc8_2");
        run_frame(2, 64'h8, 4'h5, 4'hB, "bpc4_8");
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [3:0]  c;
        for (int n = 0; n < 12; n++) begin
            d = {$urandom, $urandom};
            c = 4'($urandom_range(15));
            run_frame(n % 3, d, c, crc_model(d), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic [3:0]  ec;
        d  = {$urandom, $urandom};
        ec = crc_model(d);
        frame_to_done(1, d, 4'h4, ec, "bp");
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            iv[1] = ~iv[1];
            in_data = {$urandom, $urandom};
            in_chan = 4'($urandom_range(15));
            @(posedge clock); #1;
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== d || oc[1] !== ec || och[1] !== 4'h4 || irdy[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h crc=%h chan=%h rdy=%b required 1 %h %h 4 0",
                         n, ov[1], od[1], oc[1], och[1], irdy[1], d, ec);
            end
        end
        // Handoff with a new payload offered on the same edge: only the handoff may happen.
        @(negedge clock);
        iv[1] = 1'b1;
        ordy[1] = 1'b1;
        @(posedge clock); #1;
        iv[1] = 1'b0;
        ordy[1] = 1'b0;
        exp_fc[1]++;
        checks++;
        if (ov[1] !== 1'b0 || bsy[1] !== 1'b0 || irdy[1] !== 1'b1 || get_fc(1) !== want_fc(1)) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b rdy=%b count=%0d required 0 0 1 %0d",
                     ov[1], bsy[1], irdy[1], get_fc(1), want_fc(1));
        end
    endtask

    task automatic test_reset_midframe();
        wait_ready(0);
        @(negedge clock);
        in_data = {64{1'b1}}; in_chan = 4'hE; iv[0] = 1'b1;
        @(posedge clock); #1;
        iv[0] = 1'b0;
        repeat (30) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) exp_fc[k] = 0;
        checks++;
        if (bsy[0] !== 1'b0 || ov[0] !== 1'b0 || fc_a !== 16'h0 || irdy[0] !== 1'b0 || oc[0] !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b count=%0d rdy=%b crc=%h required 0 0 0 0 0",
                     bsy[0], ov[0], fc_a, irdy[0], oc[0]);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (70) begin
            @(posedge clock); #1;
            if (ov[0] !== 1'b0) break;
        end
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_leak: out_valid=%b required 0 after abort", ov[0]);
        end
        run_frame(0, 64'h2, 4'h0, 4'h6, "after_reset");
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        for (int n = 0; n < 17; n++) begin
            d = {$urandom, $urandom};
            run_frame(2, d, 4'(n), crc_model(d), "wrap");
        end
        checks++;
        if (fc_c !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count: frame_count=%0d required 1 after 17 handoffs", fc_c);
        end
    endtask

    initial begin
        pw[0] = 4'h1;
        for (int j = 1; j < 15; j++)
            pw[j] = pw[j-1][3] ? ({pw[j-1][2:0], 1'b0} ^ 4'h3) : {pw[j-1][2:0], 1'b0};
        for (int k = 0; k < 3; k++) exp_fc[k] = 0;

        test_reset();
        test_vectors();
        test_bpc8();
        test_random();
        test_backpressure();
        test_reset_midframe();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc4_frame_encoder.md
Name: crc4_frame_encoder

Overview:
- Transmit-side partner of the 16-channel CRC-4 frame checker.
- Accepts a 64-bit payload word with a 4-bit channel tag (channels 1..16 map to tag 0..15).
- Computes the CRC-4 of the payload serially, BITS_PER_CYCLE bits per clock.
- Presents {data, crc, channel} downstream on a valid/ready handshake, producing the DataN/CRCN pairs the checker consumes.

Parameters:
- BITS_PER_CYCLE, 1, payload bits folded into the CRC per clock; legal values 1, 2, 4, 8.
- CRC_INIT, 4'h0, CRC register seed loaded at frame accept.
- CNT_W, 16, width of the sent-frame counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  payload offered.
- in_ready  out  1  encoder can accept a payload.
- in_data  in  64  payload word, processed MSB (bit 63) first.
- in_chan  in  4  destination channel tag.
- out_valid  out  1  encoded frame available.
- out_ready  in  1  downstream accepts the frame.
- out_data  out  64  payload, unchanged.
- out_crc  out  4  CRC-4 of out_data.
- out_chan  out  4  tag captured with the payload.
- busy  out  1  high in SHIFT or DONE.
- frame_count  out  CNT_W  number of frames handed off; wraps modulo 2^CNT_W.

Behaviour:
- CRC algorithm: polynomial x^4+x+1 (0x3), no reflection, no final XOR.
- Per-bit step: fb = crc[3] ^ b; crc = {crc[2:0],0} ^ (fb ? 4'h3 : 4'h0).
- Per cycle, apply BITS_PER_CYCLE steps combinationally, MSB first.
- With CRC_INIT=0, the result equals data·x^4 mod P.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into a shift register and into out_data, latch in_chan into out_chan, load crc=CRC_INIT, beat counter=0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, consume the top BITS_PER_CYCLE bits of the shift register, shift left, increment the beat counter.
  - After 64/BITS_PER_CYCLE beats, go to DONE.
- DONE:
  - out_valid=1; out_data/out_crc/out_chan stable.
  - When out_ready=1 at a rising edge: frame_count+1, go to IDLE.
  - out_valid held indefinitely while out_ready=0 (backpressure); outputs must not change.
- Latency: payload accepted at edge E. out_valid rises after edge E+64/BITS_PER_CYCLE (64 cycles at BPC=1, 8 at BPC=8).
- Throughput: at most one frame per 64/BITS_PER_CYCLE+2 cycles.
- in_ready is a function of state only; it does not depend on out_ready. in_valid in SHIFT/DONE is ignored and the payload is not consumed.
- out_ready while not in DONE is ignored.
- Asserting in_valid and out_ready together in DONE completes the handoff only; the new payload is accepted on a later IDLE cycle.
- out_crc is written only on the DONE transition, never mid-shift.
- frame_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (asynchronous, any state, including mid-SHIFT or during DONE backpressure):
  - Returns to IDLE and discards the frame in flight.
  - Reset values: in_ready=0 while reset asserted, then 1; out_valid=0; out_data=0; out_crc=0; out_chan=0; busy=0; frame_count=0.
  - The first accept is possible on the first rising edge after reset deasserts.
- Illegal BITS_PER_CYCLE values are a synthesis-time error (generate-time check).

Test Plan:
- BPC=1, in_data=64'h2, in_chan=0 -> out_crc=4'h6 exactly 64 cycles after accept; out_data=2, out_chan=0; frame_count becomes 1 after handoff.
- BPC=1: in_data=1 -> crc 4'h3; in_data=0 -> 4'h0; in_data=64'h8 -> 4'hB; in_data=64'h8000_0000_0000_0000 -> 4'hB; in_data=all ones -> 4'h2.
- BPC=8, all-ones payload, in_chan=15 -> out_crc=4'h2, out_chan=4'hF, out_valid 8 cycles after accept; results match BPC=1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE while toggling in_valid with new data -> outputs frozen, in_ready=0, no second accept; out_ready=1 -> single handoff, frame_count+1, in_ready=1 next cycle.
- Reset at beat 30 of a BPC=1 frame -> out_valid stays 0, busy=0 immediately, frame_count=0. A new in_data=2 frame then yields crc 6, with no leakage from the aborted frame.
- CNT_W=4: send 17 frames -> frame_count reads 1 after the 17th handoff (wrap 15->0).
